// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls on RAW hazards,
// flushes on EX redirects, drains on HALT and keeps the performance counters.
module pipe_hazard_ctrl #(
   parameter int FORWARDING   = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_halt,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic              ex_is_load,
   input  logic [4:0]        ex_rd,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic [4:0]        mem_rd,
   input  logic              ex_redirect,
   input  logic [31:0]       ex_target,
   input  logic              wb_valid,
   output logic              pc_we,
   output logic              pc_sel,
   output logic [31:0]       pc_target,
   output logic              if_id_we,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  retire_cnt
);

   // DRAIN_CYCLES must be at least 1; the counter holds DRAIN_CYCLES-1.
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t          state;
   logic [DW-1:0]   drain_cnt;
   logic            ex_match;
   logic            mem_match;
   logic            raw_haz;
   logic            in_run;
   logic            take_redirect;
   logic            take_stall;
   logic            take_halt;

   function automatic logic src_match(input logic [4:0] rd,
                                      input logic [4:0] rs, input logic use_rs,
                                      input logic [4:0] rt, input logic use_rt);
      return (rd != 5'd0) && ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
   endfunction

   assign ex_match  = src_match(ex_rd,  id_rs, id_uses_rs, id_rt, id_uses_rt);
   assign mem_match = src_match(mem_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);

   // With the bypass only a load in EX is too late; without it EX and MEM writers both block.
   always_comb begin
      raw_haz = 1'b0;
      if (FORWARDING != 0)
         raw_haz = ex_valid & ex_reg_write & ex_is_load & ex_match;
      else
         raw_haz = (ex_valid & ex_reg_write & ex_match) |
                   (mem_valid & mem_reg_write & mem_match);
      raw_haz = raw_haz & id_valid;
   end

   assign in_run        = (state == S_RUN);
   assign take_redirect = in_run & ex_redirect;
   assign take_stall    = in_run & ~ex_redirect & raw_haz;
   assign take_halt     = in_run & ~ex_redirect & ~raw_haz & id_valid & id_halt;
   assign pc_target     = ex_target;

   always_comb begin
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      if (rst && in_run) begin
         if (take_redirect) begin
            pc_we       = 1'b1;
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
         end else if (!take_stall && !take_halt) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            id_ex_bubble = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_RUN;
         drain_cnt  <= '0;
         halted     <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if (wb_valid)      retire_cnt <= retire_cnt + CNT_W'(1);
         if (take_redirect) flush_cnt  <= flush_cnt + CNT_W'(1);
         if (take_stall)    stall_cnt  <= stall_cnt + CNT_W'(1);
         // halted trails the HALTED state by one edge, giving DRAIN_CYCLES+1 edges overall.
         halted <= (state == S_HALTED);
         case (state)
            S_RUN: begin
               if (take_halt) begin
                  state     <= S_DRAIN;
                  drain_cnt <= DW'(DRAIN_CYCLES - 1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0)
                  state <= S_HALTED;
               else
                  drain_cnt <= drain_cnt - DW'(1);
            end
            S_HALTED: state <= S_HALTED;
            default:  state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a bypassed 32-bit instance and a non-bypassed 4-bit-counter
// instance share one stimulus stream and are checked against a rule-level model.
module tb_pipe_hazard_ctrl;
   localparam int DRAIN = 3;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, id_valid, id_uses_rs, id_uses_rt, id_halt;
   logic        ex_valid, ex_reg_write, ex_is_load, mem_valid, mem_reg_write;
   logic        ex_redirect, wb_valid;
   logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
   logic [31:0] ex_target;

   logic        pc_we_f, pc_sel_f, if_id_we_f, if_id_flush_f, id_ex_bubble_f, halted_f;
   logic [31:0] pc_target_f, stall_cnt_f, flush_cnt_f, retire_cnt_f;
   logic        pc_we_n, pc_sel_n, if_id_we_n, if_id_flush_n, id_ex_bubble_n, halted_n;
   logic [31:0] pc_target_n;
   logic [3:0]  stall_cnt_n, flush_cnt_n, retire_cnt_n;
   logic [4:0]  ctl_f, ctl_n;

   assign ctl_f = {pc_we_f, pc_sel_f, if_id_we_f, if_id_flush_f, id_ex_bubble_f};
   assign ctl_n = {pc_we_n, pc_sel_n, if_id_we_n, if_id_flush_n, id_ex_bubble_n};

   pipe_hazard_ctrl #(.FORWARDING(1), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) u_fwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .ex_redirect(ex_redirect), .ex_target(ex_target), .wb_valid(wb_valid),
      .pc_we(pc_we_f), .pc_sel(pc_sel_f), .pc_target(pc_target_f), .if_id_we(if_id_we_f),
      .if_id_flush(if_id_flush_f), .id_ex_bubble(id_ex_bubble_f), .halted(halted_f),
      .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f), .retire_cnt(retire_cnt_f));

   pipe_hazard_ctrl #(.FORWARDING(0), .DRAIN_CYCLES(DRAIN), .CNT_W(4)) u_nof (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .ex_redirect(ex_redirect), .ex_target(ex_target), .wb_valid(wb_valid),
      .pc_we(pc_we_n), .pc_sel(pc_sel_n), .pc_target(pc_target_n), .if_id_we(if_id_we_n),
      .if_id_flush(if_id_flush_n), .id_ex_bubble(id_ex_bubble_n), .halted(halted_n),
      .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n), .retire_cnt(retire_cnt_n));

   int errs = 0;
   int checks = 0;
   // Reference state, index 0 = bypassed instance, 1 = non-bypassed instance.
   int since_halt[2];
   int stall_m[2];
   int flush_m[2];
   int retire_m;

   function automatic bit reads(input logic [4:0] r);
      return (r != 5'd0) && ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
   endfunction

   function automatic bit model_haz(input int i);
      if (!id_valid) return 1'b0;
      if (i == 0) return ex_valid && ex_reg_write && ex_is_load && reads(ex_rd);
      return (ex_valid && ex_reg_write && reads(ex_rd)) ||
             (mem_valid && mem_reg_write && reads(mem_rd));
   endfunction

   // {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble}
   function automatic logic [4:0] model_ctl(input int i);
      if (!rst)                 return 5'b00001;
      if (since_halt[i] >= 0)   return 5'b00001;
      if (ex_redirect)          return 5'b11011;
      if (model_haz(i))         return 5'b00001;
      if (id_valid && id_halt)  return 5'b00001;
      return 5'b10100;
   endfunction

   task automatic model_update;
      if (!rst) begin
         retire_m = 0;
         for (int i = 0; i < 2; i++) begin
            since_halt[i] = -1; stall_m[i] = 0; flush_m[i] = 0;
         end
      end else begin
         if (wb_valid) retire_m++;
         for (int i = 0; i < 2; i++) begin
            if (since_halt[i] >= 0) begin
               if (since_halt[i] < 1000) since_halt[i]++;
            end else if (ex_redirect) flush_m[i]++;
            else if (model_haz(i)) stall_m[i]++;
            else if (id_valid && id_halt) since_halt[i] = 0;
         end
      end
   endtask

   task automatic tick;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in;
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_halt = 0;
      ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd = 0;
      mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
      ex_redirect = 0; ex_target = 0; wb_valid = 0;
   endtask

   task automatic do_reset;
      clear_in();
      rst = 0;
      tick();
      rst = 1;
   endtask

   task automatic test_reset;
      clear_in();
      rst = 0; id_valid = 1; ex_redirect = 1; ex_target = 32'h1234; wb_valid = 1;
      #1;
      checks++; if (ctl_f !== 5'b00001) begin errs++; $display("FAIL reset_ctl: got %b expected 00001", ctl_f); end
      tick();
      checks++;
      if ({halted_f, stall_cnt_f, flush_cnt_f, retire_cnt_f} !== 97'd0) begin
         errs++; $display("FAIL reset_state: halted=%b stall=%0d flush=%0d retire=%0d expected all 0",
                          halted_f, stall_cnt_f, flush_cnt_f, retire_cnt_f);
      end
      checks++; if (ctl_n !== 5'b00001) begin errs++; $display("FAIL reset_ctl_n: got %b expected 00001", ctl_n); end
      rst = 1; clear_in();
      #1;
      checks++; if (ctl_f !== 5'b10100) begin errs++; $display("FAIL reset_release: got %b expected 10100", ctl_f); end
   endtask

   task automatic test_load_use;
      do_reset();
      ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd = 5;
      id_valid = 1; id_rs = 5; id_uses_rs = 1;
      #1;
      checks++; if (ctl_f !== 5'b00001) begin errs++; $display("FAIL load_use_ctl: got %b expected 00001", ctl_f); end
      tick();
      checks++; if (stall_cnt_f !== 32'd1) begin errs++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt_f); end
      ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd = 0;
      #1;
      checks++; if (ctl_f !== 5'b10100) begin errs++; $display("FAIL load_use_resume: got %b expected 10100", ctl_f); end
      tick();
      checks++; if (stall_cnt_f !== 32'd1) begin errs++; $display("FAIL load_use_once: got %0d expected 1", stall_cnt_f); end
   endtask

   task automatic test_no_forward;
      do_reset();
      ex_valid = 1; ex_reg_write = 1; ex_rd = 3;
      id_valid = 1; id_rt = 3; id_uses_rt = 1; id_rs = 7; id_uses_rs = 1;
      #1;
      checks++; if (ctl_n !== 5'b00001) begin errs++; $display("FAIL nofwd_ex_ctl: got %b expected 00001", ctl_n); end
      checks++; if (ctl_f !== 5'b10100) begin errs++; $display("FAIL fwd_alu_nostall: got %b expected 10100", ctl_f); end
      tick();
      ex_valid = 0; ex_reg_write = 0; ex_rd = 0;
      mem_valid = 1; mem_reg_write = 1; mem_rd = 3;
      #1;
      checks++; if (ctl_n !== 5'b00001) begin errs++; $display("FAIL nofwd_mem_ctl: got %b expected 00001", ctl_n); end
      tick();
      mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
      #1;
      checks++; if (ctl_n !== 5'b10100) begin errs++; $display("FAIL nofwd_resume: got %b expected 10100", ctl_n); end
      tick();
      checks++; if (stall_cnt_n !== 4'd2) begin errs++; $display("FAIL nofwd_cnt: got %0d expected 2", stall_cnt_n); end
      ex_valid = 1; ex_reg_write = 1; ex_rd = 0; id_rt = 0;
      #1;
      checks++; if (ctl_n !== 5'b10100) begin errs++; $display("FAIL r0_nostall: got %b expected 10100", ctl_n); end
      tick();
      checks++; if (stall_cnt_n !== 4'd2) begin errs++; $display("FAIL r0_cnt: got %0d expected 2", stall_cnt_n); end
   endtask

   task automatic test_redirect;
      do_reset();
      ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd = 5;
      id_valid = 1; id_rs = 5; id_uses_rs = 1; id_halt = 1;
      ex_redirect = 1; ex_target = 32'h40;
      #1;
      checks++; if (ctl_f !== 5'b11011) begin errs++; $display("FAIL redirect_ctl: got %b expected 11011", ctl_f); end
      checks++; if (pc_target_f !== 32'h40) begin errs++; $display("FAIL redirect_target: got %h expected 00000040", pc_target_f); end
      tick();
      checks++;
      if ({flush_cnt_f, stall_cnt_f, halted_f} !== {32'd1, 32'd0, 1'b0}) begin
         errs++; $display("FAIL redirect_cnt: flush=%0d stall=%0d halted=%b expected 1 0 0",
                          flush_cnt_f, stall_cnt_f, halted_f);
      end
      clear_in();
      #1;
      checks++; if (ctl_f !== 5'b10100) begin errs++; $display("FAIL redirect_no_drain: got %b expected 10100", ctl_f); end
      tick();
   endtask

   task automatic test_halt_and_reset;
      do_reset();
      id_valid = 1; id_halt = 1;
      #1;
      checks++; if (ctl_f !== 5'b00001) begin errs++; $display("FAIL halt_ctl: got %b expected 00001", ctl_f); end
      tick();
      clear_in();
      for (int k = 1; k <= 6; k++) begin
         ex_redirect = (k == 2); ex_target = 32'h80; wb_valid = 1;
         #1;
         checks++; if (ctl_f !== 5'b00001) begin errs++; $display("FAIL drain_ctl_%0d: got %b expected 00001", k, ctl_f); end
         tick();
         checks++; if (halted_f !== (k >= DRAIN + 1)) begin errs++; $display("FAIL halted_edge_%0d: got %b expected %b", k, halted_f, k >= DRAIN + 1); end
      end
      checks++;
      if ({flush_cnt_f, retire_cnt_f} !== {32'd0, 32'd6}) begin
         errs++; $display("FAIL drain_cnt: flush=%0d retire=%0d expected 0 6", flush_cnt_f, retire_cnt_f);
      end
      clear_in();
      rst = 0;
      #1;
      checks++; if (ctl_f !== 5'b00001) begin errs++; $display("FAIL halted_reset_ctl: got %b expected 00001", ctl_f); end
      tick();
      checks++;
      if ({halted_f, stall_cnt_f, flush_cnt_f, retire_cnt_f} !== 97'd0) begin
         errs++; $display("FAIL halted_reset_state: halted=%b retire=%0d expected 0 0", halted_f, retire_cnt_f);
      end
      rst = 1;
      #1;
      checks++; if (ctl_f !== 5'b10100) begin errs++; $display("FAIL halted_resume: got %b expected 10100", ctl_f); end
      tick();
   endtask

   task automatic test_retire_wrap;
      do_reset();
      wb_valid = 1;
      for (int k = 0; k < 15; k++) tick();
      checks++; if (retire_cnt_n !== 4'hF) begin errs++; $display("FAIL retire_near_wrap: got %0d expected 15", retire_cnt_n); end
      tick();
      checks++; if (retire_cnt_n !== 4'h0) begin errs++; $display("FAIL retire_wrap: got %0d expected 0", retire_cnt_n); end
      checks++; if (retire_cnt_f !== 32'd16) begin errs++; $display("FAIL retire_wide: got %0d expected 16", retire_cnt_f); end
      wb_valid = 0;
   endtask

   task automatic test_random;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 39) != 0);
         id_valid = ($urandom_range(0, 3) != 0);
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
         id_halt = ($urandom_range(0, 49) == 0);
         ex_valid = 1'($urandom_range(0, 1)); ex_reg_write = 1'($urandom_range(0, 1));
         ex_is_load = 1'($urandom_range(0, 1)); ex_rd = 5'($urandom_range(0, 3));
         mem_valid = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
         mem_rd = 5'($urandom_range(0, 3));
         ex_redirect = ($urandom_range(0, 5) == 0); ex_target = $urandom;
         wb_valid = 1'($urandom_range(0, 1));
         #1;
         checks++; if (ctl_f !== model_ctl(0)) begin errs++; $display("FAIL rnd_ctl_f c=%0d: got %b expected %b", c, ctl_f, model_ctl(0)); end
         checks++; if (ctl_n !== model_ctl(1)) begin errs++; $display("FAIL rnd_ctl_n c=%0d: got %b expected %b", c, ctl_n, model_ctl(1)); end
         checks++; if (pc_target_n !== ex_target) begin errs++; $display("FAIL rnd_target c=%0d: got %h expected %h", c, pc_target_n, ex_target); end
         tick();
         checks++;
         if ({stall_cnt_f, flush_cnt_f, retire_cnt_f, halted_f} !==
             {32'(stall_m[0]), 32'(flush_m[0]), 32'(retire_m), 1'(since_halt[0] > DRAIN)}) begin
            errs++; $display("FAIL rnd_reg_f c=%0d: stall=%0d flush=%0d retire=%0d halted=%b expected %0d %0d %0d %b",
                             c, stall_cnt_f, flush_cnt_f, retire_cnt_f, halted_f,
                             stall_m[0], flush_m[0], retire_m, since_halt[0] > DRAIN);
         end
         checks++;
         if ({stall_cnt_n, flush_cnt_n, retire_cnt_n, halted_n} !==
             {4'(stall_m[1]), 4'(flush_m[1]), 4'(retire_m), 1'(since_halt[1] > DRAIN)}) begin
            errs++; $display("FAIL rnd_reg_n c=%0d: stall=%0d flush=%0d retire=%0d halted=%b expected %0d %0d %0d %b (mod 16)",
                             c, stall_cnt_n, flush_cnt_n, retire_cnt_n, halted_n,
                             stall_m[1], flush_m[1], retire_m, since_halt[1] > DRAIN);
         end
      end
   endtask

   initial begin
      rst = 0;
      clear_in();
      for (int i = 0; i < 2; i++) begin
         since_halt[i] = -1; stall_m[i] = 0; flush_m[i] = 0;
      end
      retire_m = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_no_forward();
      test_redirect();
      test_halt_and_reset();
      test_retire_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
